dense_layer_seq: RTL

DENSE_LAYER_SEQ -- requirements
Module: dense_layer_seq

---
 rtl/dense_layer_seq.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/dense_layer_seq.sv
// Sequential dense layer: broadcast activation times per-engine weight, accumulated over len beats.
// Latency: result valid the cycle after the last accepted beat (the cycle after start when len is 0).
// Backpressure: in_ready_o only in ACCUM; the result is held stable until out_ready_i. Optional ReLU: DENSE_LAYER_SEQ_RELU_EN.
module dense_layer_seq #(
    parameter int N           = 8,
    parameter int EngineCount = 16,
    parameter int AccW        = 2*N+16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                start_i,
    input  logic [15:0]         len_i,
    input  logic [11:0]         active_i,
    input  logic [5:0]          shift_i,
    input  logic                accumulate_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic signed [N-1:0] value_i,
    input  logic signed [N-1:0] weight_i [EngineCount],
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic signed [N-1:0] dense_o [EngineCount],
    output logic                busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_OUTPUT
    } state_t;

    // Saturation bounds expressed at the widened rounding width.
    localparam logic signed [AccW:0] SAT_MAX = $signed({{(AccW-N+2){1'b0}}, {(N-1){1'b1}}});
    localparam logic signed [AccW:0] SAT_MIN = $signed({{(AccW-N+2){1'b1}}, {(N-1){1'b0}}});
    localparam logic [AccW:0]        RND_ONE = {{AccW{1'b0}}, 1'b1};

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_start;
    logic        w_accept;
    logic [15:0] r_len;
    logic [15:0] r_cnt;
    logic [11:0] r_active;
    logic [5:0]  r_shift;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        w_start     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_start     = 1'b1;
                    w_state_nxt = (len_i == 16'd0) ? S_OUTPUT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                in_ready_o = 1'b1;
                if (in_valid_i) begin
                    w_accept = 1'b1;
                    // r_len is nonzero here, so len-1 never underflows.
                    if (r_cnt == r_len - 16'd1) begin
                        w_state_nxt = S_OUTPUT;
                    end
                end
            end
            S_OUTPUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                busy_o      = 1'b0;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Latch run configuration at start and count accepted beats
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_len    <= '0;
            r_active <= '0;
            r_shift  <= '0;
            r_cnt    <= '0;
        end else if (w_start) begin
            r_len    <= len_i;
            r_active <= active_i;
            r_shift  <= shift_i;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    for (genvar g = 0; g < EngineCount; g++) begin : g_eng
        localparam logic [11:0] EIDX = 12'(g);

        logic signed [AccW-1:0]  r_acc;
        logic signed [2*N-1:0]   w_prod;
        logic signed [AccW:0]    w_ext;
        logic signed [AccW:0]    w_sum;
        logic signed [AccW:0]    w_sh;
        logic [AccW:0]           w_rnd;
        logic signed [N-1:0]     w_sat;
        logic signed [N-1:0]     w_act;
        logic                    w_en;

        assign w_en   = (EIDX < r_active);
        assign w_prod = value_i * weight_i[g];

        // Accumulator: optional clear at start, multiply-accumulate on accepted beats
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                r_acc <= '0;
            end else if (w_start && !accumulate_i) begin
                r_acc <= '0;
            end else if (w_accept && w_en) begin
                r_acc <= r_acc + AccW'(w_prod);
            end
        end

        // Round half-up then arithmetic shift, one bit wider than the accumulator
        assign w_ext = {r_acc[AccW-1], r_acc};
        assign w_rnd = (r_shift != 6'd0) ? (RND_ONE << (r_shift - 6'd1)) : '0;
        assign w_sum = w_ext + $signed(w_rnd);
        assign w_sh  = w_sum >>> r_shift;

        // Saturate to the output range and apply the optional ReLU
        always_comb begin
            if (w_sh > SAT_MAX) begin
                w_sat = SAT_MAX[N-1:0];
            end else if (w_sh < SAT_MIN) begin
                w_sat = SAT_MIN[N-1:0];
            end else begin
                w_sat = w_sh[N-1:0];
            end
`ifdef DENSE_LAYER_SEQ_RELU_EN
            w_act = w_sat[N-1] ? '0 : w_sat;
`else
            w_act = w_sat;
`endif
        end

        assign dense_o[g] = (out_valid_o && w_en) ? w_act : '0;
    end

endmodule
